// File: rtl/fp32_dot_accumulator_if.sv
// Product-in / result-out handshake bundle for fp32_dot_accumulator.
// master drives products and accepts results; slave is the accumulator.
interface fp32_dot_accumulator_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_count
   );
endinterface

// File: rtl/fp32_dot_accumulator.sv
// Multi-cycle FP32 RNE accumulator: one product per 5 cycles, one result per in_last stream.
// Define FLUSH_DENORM_EN to flush denormal inputs and denormal results to signed zero.
module fp32_dot_accumulator #(
   parameter int unsigned CNT_W = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   fp32_dot_accumulator_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] man;
   } op_t;

   state_t           state_q;
   logic [31:0]      acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      in_q;
   logic             last_q;
   logic             rdy_q;
   logic             ovalid_q;
   logic [31:0]      odata_q;
   logic [CNT_W-1:0] ocount_q;

   logic             sign_q;
   logic [9:0]       exp_q;
   logic [26:0]      a_man_q;
   logic [26:0]      b_man_q;
   logic             sub_q;
   logic [27:0]      sum_q;
   logic [26:0]      man_q;
   logic             special_q;
   logic [31:0]      special_val_q;

   // Denormals share the minimum exponent with a clear hidden bit.
   function automatic op_t unpack(input logic [31:0] x);
      op_t o;
      o.sign = x[31];
      o.exp  = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
`ifdef FLUSH_DENORM_EN
      o.man  = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
`else
      o.man  = {(x[30:23] != 8'd0), x[22:0]};
`endif
      return o;
   endfunction

   // ALIGN datapath
   op_t         acc_op, in_op, op_a, op_b;
   logic [7:0]  exp_diff;
   logic [53:0] shift_tmp;
   logic [26:0] b_aligned;
   logic        acc_nan, in_nan, acc_inf, in_inf;
   logic        special_d;
   logic [31:0] special_val_d;

   always_comb begin
      acc_op = unpack(acc_q);
      in_op  = unpack(in_q);
      if ({acc_op.exp, acc_op.man} >= {in_op.exp, in_op.man}) begin
         op_a = acc_op;
         op_b = in_op;
      end else begin
         op_a = in_op;
         op_b = acc_op;
      end
      exp_diff  = op_a.exp - op_b.exp;
      // 27 zero bits below the field catch every bit shifted past the sticky position.
      shift_tmp = {op_b.man, 3'b000, 27'd0} >> exp_diff;
      if (exp_diff >= 8'd27) begin
         b_aligned = {26'd0, |op_b.man};
      end else begin
         b_aligned = shift_tmp[53:27] | {26'd0, |shift_tmp[26:0]};
      end

      acc_nan   = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] != 23'd0);
      in_nan    = (in_q[30:23] == 8'hFF) && (in_q[22:0] != 23'd0);
      acc_inf   = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] == 23'd0);
      in_inf    = (in_q[30:23] == 8'hFF) && (in_q[22:0] == 23'd0);
      special_d = acc_nan | in_nan | acc_inf | in_inf;
      if (acc_nan || in_nan || (acc_inf && in_inf && (acc_q[31] != in_q[31]))) begin
         special_val_d = 32'hFFC0_0000;
      end else if (acc_inf) begin
         special_val_d = acc_q;
      end else begin
         special_val_d = in_q;
      end
   end

   // ADD datapath; A >= B in magnitude so the difference never goes negative.
   logic [27:0] sum_d;

   always_comb begin
      if (sub_q) begin
         sum_d = {1'b0, a_man_q} - {1'b0, b_man_q};
      end else begin
         sum_d = {1'b0, a_man_q} + {1'b0, b_man_q};
      end
   end

   // NORM datapath
   logic [4:0]  lzc;
   logic [9:0]  shift_amt;
   logic [26:0] norm_man;
   logic [9:0]  norm_exp;

   always_comb begin
      lzc = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (sum_q[i]) lzc = 5'(26 - i);
      end
      shift_amt = 10'd0;
      if (sum_q[27]) begin
         norm_man = {sum_q[27:2], sum_q[1] | sum_q[0]};
         norm_exp = exp_q + 10'd1;
      end else begin
         // Never shift below the minimum exponent: gradual underflow.
         shift_amt = ({5'd0, lzc} > (exp_q - 10'd1)) ? (exp_q - 10'd1) : {5'd0, lzc};
         norm_man  = sum_q[26:0] << shift_amt;
         norm_exp  = exp_q - shift_amt;
      end
   end

   // ROUND datapath
   logic        round_up;
   logic [24:0] rnd_man;
   logic [9:0]  rnd_exp;
   logic [31:0] result;

   always_comb begin
      round_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
      rnd_man  = {1'b0, man_q[26:3]} + {24'd0, round_up};
      rnd_exp  = exp_q;
      if (rnd_man[24]) begin
         rnd_man = rnd_man >> 1;
         rnd_exp = exp_q + 10'd1;
      end
      if (special_q) begin
         result = special_val_q;
      end else if (rnd_exp >= 10'd255) begin
         result = {sign_q, 8'hFF, 23'd0};
      end else if (!rnd_man[23]) begin
`ifdef FLUSH_DENORM_EN
         result = {sign_q, 31'd0};
`else
         result = {sign_q, 8'd0, rnd_man[22:0]};
`endif
      end else begin
         result = {sign_q, rnd_exp[7:0], rnd_man[22:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         acc_q         <= 32'd0;
         cnt_q         <= '0;
         in_q          <= 32'd0;
         last_q        <= 1'b0;
         rdy_q         <= 1'b0;
         ovalid_q      <= 1'b0;
         odata_q       <= 32'd0;
         ocount_q      <= '0;
         sign_q        <= 1'b0;
         exp_q         <= 10'd0;
         a_man_q       <= 27'd0;
         b_man_q       <= 27'd0;
         sub_q         <= 1'b0;
         sum_q         <= 28'd0;
         man_q         <= 27'd0;
         special_q     <= 1'b0;
         special_val_q <= 32'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.in_valid && rdy_q) begin
                  in_q    <= bus.in_data;
                  last_q  <= bus.in_last;
                  rdy_q   <= 1'b0;
                  state_q <= StAlign;
                  if (cnt_q != '1) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  rdy_q <= 1'b1;
               end
            end
            StAlign: begin
               sign_q        <= op_a.sign;
               exp_q         <= {2'b00, op_a.exp};
               a_man_q       <= {op_a.man, 3'b000};
               b_man_q       <= b_aligned;
               sub_q         <= op_a.sign ^ op_b.sign;
               special_q     <= special_d;
               special_val_q <= special_val_d;
               state_q       <= StAdd;
            end
            StAdd: begin
               sum_q <= sum_d;
               if (sub_q && (sum_d == 28'd0)) sign_q <= 1'b0;
               state_q <= StNorm;
            end
            StNorm: begin
               man_q   <= norm_man;
               exp_q   <= norm_exp;
               state_q <= StRound;
            end
            StRound: begin
               acc_q <= result;
               if (last_q) begin
                  ovalid_q <= 1'b1;
                  odata_q  <= result;
                  ocount_q <= cnt_q;
                  state_q  <= StDone;
               end else begin
                  rdy_q   <= 1'b1;
                  state_q <= StIdle;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  ovalid_q <= 1'b0;
                  acc_q    <= 32'd0;
                  cnt_q    <= '0;
                  rdy_q    <= 1'b1;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = ovalid_q;
   assign bus.out_data  = odata_q;
   assign bus.out_count = ocount_q;

endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Randomized bench for fp32_dot_accumulator; reference sums in double precision and
// rounds each partial sum back to FP32 (exact for a single add), plus directed corner cases.
module tb_fp32_dot_accumulator;

   localparam int unsigned CNT_W = 16;
`ifdef FLUSH_DENORM_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fp32_dot_accumulator_if #(.CNT_W(CNT_W)) bus ();

   fp32_dot_accumulator #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad = 0;
   logic [31:0] sq[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] f2d(input logic [31:0] f);
      logic [23:0] m;
      int ex;
      if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'd0};
      if (f[30:23] == 8'd0) begin
         if (f[22:0] == 23'd0 || FLUSH) return {f[31], 63'd0};
         m  = {1'b0, f[22:0]};
         ex = -126;
         for (int k = 0; k < 23; k++) begin
            if (!m[23]) begin
               m  = m << 1;
               ex = ex - 1;
            end
         end
      end else begin
         m  = {1'b1, f[22:0]};
         ex = int'(f[30:23]) - 127;
      end
      return {f[31], 11'(ex + 1023), m[22:0], 29'd0};
   endfunction

   function automatic logic [31:0] d2f(input logic [63:0] d);
      int e, sh;
      logic [63:0] sig, kept, rem, half, r;
      if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 32'hFFC0_0000 : {d[63], 8'hFF, 23'd0};
      if (d[62:52] == 11'd0) return {d[63], 31'd0};
      e   = int'(d[62:52]) - 1023;
      sig = {11'd0, 1'b1, d[51:0]};
      sh  = (e >= -126) ? 29 : (-97 - e);
      if (sh > 60) sh = 60;
      kept = sig >> sh;
      rem  = sig & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
      if (e >= -126) r = (64'(e + 126) << 23) + kept;
      else r = kept;
      if (r >= 64'h7F80_0000) return {d[63], 8'hFF, 23'd0};
      if (FLUSH && r[30:23] == 8'd0) return {d[63], 31'd0};
      return {d[63], r[30:0]};
   endfunction

   function automatic logic [31:0] model_sum(input logic [31:0] elems[$]);
      logic [31:0] acc;
      acc = 32'd0;
      foreach (elems[i]) acc = d2f($realtobits($bitstoreal(f2d(acc)) + $bitstoreal(f2d(elems[i]))));
      return acc;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[30:23] = 8'd0;
         1: r[30:0] = 31'd0;
         2: r[30:23] = 8'($urandom_range(1, 254));
         default: r[30:23] = 8'($urandom_range(118, 130));
      endcase
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic send(input logic [31:0] d, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check_eq("send timeout", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // lat counts edges after the accepting edge until out_valid is seen (4 => cycle k+5).
   task automatic recv(input string tag, input int stall, output logic [31:0] d,
                       output logic [CNT_W-1:0] c, output int lat);
      int n;
      n = 0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      if (!bus.out_valid) check_eq({tag, " timeout"}, bus.out_valid, 1);
      repeat (stall) @(negedge clk);
      d = bus.out_data;
      c = bus.out_count;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic run_stream(input string tag, input logic [31:0] elems[$],
                             input logic [31:0] want, input int stall);
      logic [31:0] d;
      logic [CNT_W-1:0] c;
      int lat;
      foreach (elems[i]) send(elems[i], (i == elems.size() - 1));
      recv(tag, stall, d, c, lat);
      check_eq({tag, " data"}, d, want);
      check_eq({tag, " count"}, c, elems.size());
      check_eq({tag, " latency"}, lat, 4);
   endtask

   // ---------------- sequence ----------------
   initial begin
      int n;
      int len;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'd0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst in_ready", bus.in_ready, 0);
      check_eq("rst out_valid", bus.out_valid, 0);
      check_eq("rst out_data", bus.out_data, 0);
      check_eq("rst out_count", bus.out_count, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle in_ready", bus.in_ready, 1);

      sq.delete(); sq.push_back(32'h3F80_0000); sq.push_back(32'h4000_0000);
      sq.push_back(32'h4040_0000);
      run_stream("sum123", sq, 32'h40C0_0000, 0);
      sq.delete(); sq.push_back(32'h3F80_0000); sq.push_back(32'h3380_0000);
      run_stream("tie_even", sq, 32'h3F80_0000, 0);
      sq.delete(); sq.push_back(32'h3F80_0000); sq.push_back(32'h33C0_0000);
      run_stream("round_up", sq, 32'h3F80_0001, 1);
      sq.delete(); sq.push_back(32'h7F80_0000); sq.push_back(32'hFF80_0000);
      run_stream("inf_minus_inf", sq, 32'hFFC0_0000, 0);
      sq.delete(); sq.push_back(32'h7F7F_FFFF); sq.push_back(32'h7F7F_FFFF);
      run_stream("overflow", sq, 32'h7F80_0000, 0);
      sq.delete(); sq.push_back(32'h3F80_0000); sq.push_back(32'hBF80_0000);
      run_stream("cancel", sq, 32'h0000_0000, 0);
      sq.delete(); sq.push_back(32'h0000_0001); sq.push_back(32'h0000_0001);
      run_stream("denorm", sq, FLUSH ? 32'h0000_0000 : 32'h0000_0002, 0);
      sq.delete(); sq.push_back(32'h7FC0_0001);
      run_stream("nan_canon", sq, 32'hFFC0_0000, 0);
      sq.delete(); sq.push_back(32'h7FC0_0000); sq.push_back(32'h3F80_0000);
      run_stream("nan_sticky", sq, 32'hFFC0_0000, 0);
      sq.delete(); sq.push_back(32'hFF80_0000); sq.push_back(32'h4000_0000);
      run_stream("inf_finite", sq, 32'hFF80_0000, 0);

      // Backpressure: result must hold while out_ready stays low.
      send(32'h4040_0000, 1'b1);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         check_eq("bp out_valid", bus.out_valid, 1);
         check_eq("bp out_data", bus.out_data, 32'h4040_0000);
         check_eq("bp out_count", bus.out_count, 1);
         check_eq("bp in_ready", bus.in_ready, 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      check_eq("bp released", bus.out_valid, 0);
      sq.delete(); sq.push_back(32'h3F80_0000);
      run_stream("after_bp", sq, 32'h3F80_0000, 0);

      // Reset during ADD of the second element of a three-element stream.
      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort in_ready", bus.in_ready, 0);
      check_eq("abort out_valid", bus.out_valid, 0);
      check_eq("abort out_data", bus.out_data, 0);
      check_eq("abort out_count", bus.out_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sq.delete(); sq.push_back(32'h4000_0000);
      run_stream("post_reset", sq, 32'h4000_0000, 0);

      // Random streams, some with a near-negation of the running sum to force cancellation.
      for (int s = 0; s < 40; s++) begin
         len = $urandom_range(1, 6);
         sq.delete();
         for (int i = 0; i < len; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
               sq.push_back(model_sum(sq) ^ 32'h8000_0000 ^ 32'($urandom_range(0, 15)));
            end else begin
               sq.push_back(rand_fp());
            end
         end
         run_stream($sformatf("rand%0d", s), sq, model_sum(sq), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
